// File: rtl/ihp_clk_div.sv
// ihp_clk_div: runtime-programmable integer clock divider with handshaked divisor updates applied at period boundaries
module ihp_clk_div #(
  parameter int DIV_W = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             tick_o,
  output logic             clk_o
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
  logic pend_q, pend_d, run_q, run_d, out_q, out_d, sel_q, sel_d;
  logic wrap, apply, accept;
  always_comb begin
    wrap = cnt_q == div_q - ONE;
    accept = div_valid_i & ~pend_q;
    apply = pend_q & (~sel_q | wrap);
    div_d = apply ? pdiv_q : div_q;
    sel_d = apply ? |pdiv_q[DIV_W-1:1] : sel_q;
    cnt_d = (apply | ~sel_q | wrap) ? '0 : cnt_q + ONE;
    run_d = ~sel_d ? 1'b0 : (apply | wrap) ? en_i : run_q;
    out_d = run_d & (cnt_d < (div_d >> 1));
    pend_d = accept | (pend_q & ~apply);
    pdiv_d = accept ? div_i : pdiv_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= DEF;
      pdiv_q <= '0;
      pend_q <= 1'b0;
      run_q <= 1'b0;
      out_q <= 1'b0;
      sel_q <= DEFAULT_DIV >= 2;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      run_q <= run_d;
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end
  assign div_ready_o = ~pend_q;
  assign tick_o = run_q & (cnt_q == '0);
  // out_q only changes on the edge that also switches the mux, while both inputs are high
  ihp_clk_mux2 u_mux (
    .clk0_i(clk_i),
    .clk1_i(out_q),
    .sel_i (sel_q & ~test_mode_i),
    .clk_o (clk_o)
  );
endmodule

module ihp_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);
  assign clk_o = sel_i ? clk1_i : clk0_i;
endmodule

// File: tb/tb_ihp_clk_div.sv
// tb_ihp_clk_div: table vectors, corner sequences and random traffic against a waveform-queue reference model
module tb_ihp_clk_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  logic en = 1'b0;
  logic div_valid = 1'b0;
  logic [7:0] div = 8'd0;
  logic div_ready, tick, clk_out;
  int checks = 0;
  int failures = 0;
  int m_n = 1;
  int m_pdiv = 0;
  bit m_sel = 1'b0;
  bit m_pend = 1'b0;
  bit m_run = 1'b0;
  bit q[$];
  typedef struct {
    int d;
    int hi;
    int lo;
  } vec_t;
  vec_t tbl[7];

  ihp_clk_div #(.DIV_W(8), .DEFAULT_DIV(1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_mode_i(test_mode),
    .en_i       (en),
    .div_i      (div),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready),
    .tick_o     (tick),
    .clk_o      (clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: the current divided period is a queue of output levels, one per clk_i cycle
  task automatic start_period();
    m_run = en;
    q.delete();
    for (int i = 0; i < m_n; i++) q.push_back(en && (i < m_n / 2));
  endtask

  task automatic model_reset();
    m_n = 1;
    m_sel = 1'b0;
    m_pend = 1'b0;
    m_pdiv = 0;
    m_run = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    bit acc, bnd, app;
    acc = div_valid && !m_pend;
    bnd = m_sel && (q.size() == 1);
    app = m_pend && (bnd || !m_sel);
    if (app) begin
      m_n = m_pdiv;
      m_sel = m_pdiv >= 2;
      m_pend = 1'b0;
      if (m_sel) start_period();
      else begin
        m_run = 1'b0;
        q.delete();
      end
    end else if (m_sel) begin
      q.delete(0);
      if (q.size() == 0) start_period();
    end
    if (acc) begin
      m_pend = 1'b1;
      m_pdiv = int'(div);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  function automatic bit exp_clk();
    bit o;
    o = m_sel && (q.size() > 0) && q[0];
    return (m_sel && !test_mode) ? o : clk;
  endfunction

  function automatic bit exp_tick();
    return m_sel && m_run && (q.size() == m_n);
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    chk("mon_clk_o_high_phase", clk_out, exp_clk());
  end

  initial forever begin
    @(negedge clk);
    #2;
    chk("mon_clk_o_low_phase", clk_out, exp_clk());
    chk("mon_tick_o", tick, exp_tick());
    chk("mon_div_ready_o", div_ready, !m_pend);
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_div(input logic [7:0] d);
    int n;
    step();
    div = d;
    div_valid = 1'b1;
    for (n = 0; n < 700 && !div_ready; n++) step();
    chk("send_div_accept", div_ready, 1);
    step();
    div_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    for (n = 0; n < 700; n++) begin
      step();
      if (tick && div_ready) break;
    end
    chk(name, n < 700, 1);
  endtask

  initial begin
    int hi, tk, lows, n;
    logic first;
    tbl[0] = '{2, 1, 1};
    tbl[1] = '{3, 1, 2};
    tbl[2] = '{4, 2, 2};
    tbl[3] = '{5, 2, 3};
    tbl[4] = '{8, 4, 4};
    tbl[5] = '{9, 4, 5};
    tbl[6] = '{255, 127, 128};
    repeat (3) step();
    chk("rst_ready", div_ready, 1);
    chk("rst_tick", tick, 0);
    chk("rst_clk_low", clk_out, 0);
    @(posedge clk);
    #1;
    chk("rst_clk_high", clk_out, 1);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("bypass_after_reset", clk_out, 0);
    en = 1'b1;
    foreach (tbl[k]) begin
      send_div(8'(tbl[k].d));
      wait_start("tbl_start");
      hi = 0;
      tk = 0;
      first = clk_out;
      for (int i = 0; i < tbl[k].d; i++) begin
        hi += int'(clk_out);
        tk += int'(tick);
        step();
      end
      chk("tbl_first_high", first, 1);
      chk("tbl_high_cycles", hi, tbl[k].hi);
      chk("tbl_low_cycles", tbl[k].d - hi, tbl[k].lo);
      chk("tbl_ticks_per_period", tk, 1);
      chk("tbl_next_tick", tick, 1);
    end
    send_div(8'd5);
    wait_start("t3_start");
    div = 8'd3;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    lows = 0;
    for (n = 0; n < 20 && !div_ready; n++) begin
      lows++;
      step();
    end
    chk("t3_ready_low_cycles", lows, 4);
    chk("t3_tick_at_wrap", tick, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_wave", clk_out, i == 0);
      step();
    end
    chk("t3_next_tick", tick, 1);
    send_div(8'd4);
    wait_start("t4_start");
    step();
    en = 1'b0;
    chk("t4_period_completes", clk_out, 1);
    hi = 0;
    tk = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      hi += int'(clk_out);
      tk += int'(tick);
    end
    chk("t4_held_low", hi, 0);
    chk("t4_no_ticks", tk, 0);
    en = 1'b1;
    step();
    chk("t4_no_runt_clk", clk_out, 0);
    chk("t4_no_runt_tick", tick, 0);
    step();
    chk("t4_resume_tick", tick, 1);
    chk("t4_resume_clk", clk_out, 1);
    send_div(8'd6);
    wait_start("t5_start");
    send_div(8'd1);
    for (n = 0; n < 20 && !div_ready; n++) step();
    chk("t5_bypass_ready", div_ready, 1);
    @(posedge clk);
    #1;
    chk("t5_bypass_high", clk_out, 1);
    step();
    chk("t5_bypass_low", clk_out, 0);
    send_div(8'd6);
    wait_start("t5_redivide");
    chk("t5_high_at_apply", clk_out, 1);
    test_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t5_test_mode_high", clk_out, 1);
      step();
      chk("t5_test_mode_low", clk_out, 0);
    end
    test_mode = 1'b0;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          n = int'($urandom_range(0, 19));
          send_div(n == 0 ? 8'd255 : n == 1 ? 8'd0 : 8'($urandom_range(1, 9)));
        end
        3: en = 1'($urandom_range(0, 1));
        4: test_mode = ($urandom_range(0, 7) == 0);
        default: repeat ($urandom_range(1, 8)) step();
      endcase
    end
    test_mode = 1'b0;
    en = 1'b1;
    send_div(8'd8);
    wait_start("t6_start");
    div = 8'd2;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("t6_pending", div_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", div_ready, 1);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_clk_low", clk_out, 0);
    @(posedge clk);
    #1;
    chk("t6_rst_clk_high", clk_out, 1);
    step();
    rst_n = 1'b1;
    tk = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      tk += int'(tick);
      chk("t6_discarded_ready", div_ready, 1);
    end
    chk("t6_discarded_ticks", tk, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
